kmc_mpram_gen: RTL and testbench
================================

// Module: kmc_mpram_gen
//
// PURPOSE
//   Parametrised multiport register file for the KMC11-class microprocessor.
//   Holds NCSR host-visible 16-bit CSR words and NNPR DMA channels (IN/OUT data and address words).
//   Each byte is writable by the host bus, by microcode (ALU byte) or by DMA capture.
//   Collisions defer the microcode write through a one-deep pending buffer (mpBUSY), never drop it.
//   Per-byte host-dirty flags tell microcode which CSR bytes the host has written.
//
// PARAMETERS
//   NCSR   4   number of 16-bit CSR words (>=1); CSR byte space = 2*NCSR bytes
//   NNPR   1   number of NPR channels (>=1); NPR byte space = 8*NNPR bytes
//   IW     8   width of microcode byte index mpWADDR/mpRADDR
//
// PORTS
//   clk        in   1          clock
//   rst        in   1          synchronous reset, active high
//   hostWR     in   1          host CSR word write strobe
//   hostSEL    in   $clog2(NCSR) target CSR word
//   hostLOBYTE in   1          host write enable, bits [7:0]
//   hostHIBYTE in   1          host write enable, bits [15:8]
//   hostDATA   in   16         host write data
//   dmaACK     in   1          DMA data phase complete (capture strobe)
//   dmaCHAN    in   $clog2(NNPR) DMA channel (max(1,..) bits)
//   dmaOUT     in   1          0: NPR read -> capture into ID; 1: NPR write -> capture into OD
//   dmaLOBYTE  in   1          DMA byte enable [7:0]
//   dmaHIBYTE  in   1          DMA byte enable [15:8]
//   dmaDATA    in   16         DMA data
//   mpWR       in   1          microcode byte write strobe
//   mpWSPACE   in   1          0: CSR space, 1: NPR space
//   mpWADDR    in   IW         byte index within space
//   mpWDATA    in   8          ALU byte
//   mpRD       in   1          microcode read strobe (clears dirty flag of read CSR byte)
//   mpRSPACE   in   1          read space
//   mpRADDR    in   IW         read byte index
//   mpRDATA    out  8          read data (combinational; 0 if index out of range)
//   mpBUSY     out  1          pending microcode write outstanding
//   mpERR      out  1          one-cycle pulse: mpWR issued while mpBUSY, write dropped
//   csrOUT     out  16*NCSR    CSR words, word k at [16k+15:16k]
//   csrDIRTY   out  2*NCSR     per-byte host-written flags
//   nprID/OD/IA/OA out 16*NNPR NPR in-data, out-data, in-addr, out-addr per channel
//
// BEHAVIOUR
//   - Reset: all CSR/NPR bytes 0, csrDIRTY 0, pending cleared, mpBUSY 0, mpERR 0. Reset mid-deferral discards pending write.
//   - CSR byte index b: word b>>1, b[0]=1 selects high byte. NPR index = chan*8+sel;
//     sel 0..7 = IDL,IDH,ODL,ODH,IAL,IAH,OAL,OAH. Out-of-range write ignored (no busy, no err).
//   - All writes take effect at the next rising clk; mpRDATA reflects register state (no bypass).
//   - Priority per byte: host (CSR) or DMA (NPR) > pending microcode > new mpWR.
//   - Collision: accepted mpWR (or pending retry) targeting a byte written same cycle by host/DMA -> loses;
//     stored as {space,addr,data} in pending buffer, mpBUSY=1 next cycle. Retried every cycle until it
//     wins; on winning, pending clears and mpBUSY drops the following cycle. Non-colliding mpWR: 1-cycle latency.
//   - mpWR while mpBUSY=1: dropped, mpERR=1 next cycle for one cycle; pending unaffected.
//   - DMA capture: dmaOUT=0 writes ID bytes, dmaOUT=1 writes OD bytes of channel dmaCHAN per byte enables.
//     IA/OA written by microcode only.
//   - Dirty: host byte write sets csrDIRTY[b]; mpRD with mpRSPACE=0 clears csrDIRTY[mpRADDR].
//     Same-cycle set and clear on one byte -> set wins (flag stays 1).
//   - Microcode writes to CSR bytes do not affect csrDIRTY.
//
// TESTING
//   1. Reset, NCSR=4: host WR sel=2 lo+hi 0xBEEF -> csrOUT[47:32]=0xBEEF, csrDIRTY=8'b0011_0000.
//   2. Same cycle host lo-byte 0x12 to CSR0 and mpWR CSR idx0 0x34 -> CSR0[7:0]=0x12, mpBUSY=1 one cycle, then 0x34.
//   3. mpWR while mpBUSY -> mpERR pulses 1 cycle, dropped write absent, pending still lands.
//   4. NNPR=2: dmaACK chan1 dmaOUT=0 data 0xA55A both bytes -> nprID[31:16]=0xA55A; chan0 untouched.
//   5. mpRD idx4 same cycle as host write CSR2 lo -> csrDIRTY[4] stays 1; next mpRD alone -> clears.
//   6. rst asserted while mpBUSY=1 -> next cycle mpBUSY=0, all outputs 0, deferred write never applied.

Source files
------------

// File: rtl/kmc_mpram_gen.sv
// Multiport CSR/NPR byte register file: host, DMA and microcode writers with deferred microcode retry.
// Latency: all writes land at the next clk edge; mpRDATA is combinational from register state.
// Backpressure: a microcode write that collides is held in a one-deep buffer (mpBUSY); mpWR while busy is dropped with mpERR.
module kmc_mpram_gen #(
    parameter int NCSR = 4,
    parameter int NNPR = 1,
    parameter int IW   = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    hostWR,
    input  logic [((NCSR > 1) ? $clog2(NCSR) : 1)-1:0] hostSEL,
    input  logic                                    hostLOBYTE,
    input  logic                                    hostHIBYTE,
    input  logic [15:0]                             hostDATA,
    input  logic                                    dmaACK,
    input  logic [((NNPR > 1) ? $clog2(NNPR) : 1)-1:0] dmaCHAN,
    input  logic                                    dmaOUT,
    input  logic                                    dmaLOBYTE,
    input  logic                                    dmaHIBYTE,
    input  logic [15:0]                             dmaDATA,
    input  logic                                    mpWR,
    input  logic                                    mpWSPACE,
    input  logic [IW-1:0]                           mpWADDR,
    input  logic [7:0]                              mpWDATA,
    input  logic                                    mpRD,
    input  logic                                    mpRSPACE,
    input  logic [IW-1:0]                           mpRADDR,
    output logic [7:0]                              mpRDATA,
    output logic                                    mpBUSY,
    output logic                                    mpERR,
    output logic [16*NCSR-1:0]                      csrOUT,
    output logic [2*NCSR-1:0]                       csrDIRTY,
    output logic [16*NNPR-1:0]                      nprID,
    output logic [16*NNPR-1:0]                      nprOD,
    output logic [16*NNPR-1:0]                      nprIA,
    output logic [16*NNPR-1:0]                      nprOA
);

    localparam int CSR_BYTES = 2 * NCSR;
    localparam int NPR_BYTES = 8 * NNPR;

    logic [7:0]           csr_q [CSR_BYTES];
    logic [7:0]           csr_d [CSR_BYTES];
    logic [7:0]           npr_q [NPR_BYTES];
    logic [7:0]           npr_d [NPR_BYTES];
    logic [CSR_BYTES-1:0] dirty_q, dirty_d;
    logic                 pend_vld_q, pend_vld_d;
    logic                 pend_sp_q, pend_sp_d;
    logic [IW-1:0]        pend_addr_q, pend_addr_d;
    logic [7:0]           pend_data_q, pend_data_d;
    logic                 err_q, err_d;

    // The microcode write considered this cycle: the pending retry if any, else a fresh mpWR
    logic                 mw_vld;
    logic                 mw_sp;
    logic [IW-1:0]        mw_addr;
    logic [7:0]           mw_data;
    logic                 mw_hit;
    logic                 host_we;
    logic                 dma_we;
    logic                 mw_here;
    logic                 rd_clr;

    // Per-byte arbitration: host/DMA win, a losing microcode write moves into the pending buffer
    always_comb begin
        csr_d       = csr_q;
        npr_d       = npr_q;
        dirty_d     = dirty_q;
        pend_vld_d  = pend_vld_q;
        pend_sp_d   = pend_sp_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        err_d       = mpWR & pend_vld_q;
        mw_vld      = pend_vld_q | mpWR;
        mw_sp       = pend_vld_q ? pend_sp_q   : mpWSPACE;
        mw_addr     = pend_vld_q ? pend_addr_q : mpWADDR;
        mw_data     = pend_vld_q ? pend_data_q : mpWDATA;
        mw_hit      = 1'b0;
        host_we     = 1'b0;
        dma_we      = 1'b0;
        mw_here     = 1'b0;
        rd_clr      = 1'b0;

        for (int b = 0; b < CSR_BYTES; b++) begin
            host_we = hostWR && (32'(hostSEL) == 32'(b / 2)) &&
                      (((b % 2) == 1) ? hostHIBYTE : hostLOBYTE);
            mw_here = mw_vld && !mw_sp && (32'(mw_addr) == 32'(b));
            rd_clr  = mpRD && !mpRSPACE && (32'(mpRADDR) == 32'(b));
            if (host_we) begin
                csr_d[b] = ((b % 2) == 1) ? hostDATA[15:8] : hostDATA[7:0];
                if (mw_here) mw_hit = 1'b1;
            end else if (mw_here) begin
                csr_d[b] = mw_data;
            end
            // a host write in the same cycle as a read-clear keeps the flag set
            dirty_d[b] = (dirty_q[b] & ~rd_clr) | host_we;
        end

        for (int b = 0; b < NPR_BYTES; b++) begin
            // byte select within a channel: 0/1 = ID, 2/3 = OD; DMA never touches IA/OA
            dma_we  = dmaACK && (32'(dmaCHAN) == 32'(b / 8)) &&
                      (((b % 8) / 2) == (dmaOUT ? 1 : 0)) &&
                      (((b % 2) == 1) ? dmaHIBYTE : dmaLOBYTE);
            mw_here = mw_vld && mw_sp && (32'(mw_addr) == 32'(b));
            if (dma_we) begin
                npr_d[b] = ((b % 2) == 1) ? dmaDATA[15:8] : dmaDATA[7:0];
                if (mw_here) mw_hit = 1'b1;
            end else if (mw_here) begin
                npr_d[b] = mw_data;
            end
        end

        // out-of-range targets never hit a byte, so they simply vanish
        if (mw_vld && mw_hit) begin
            pend_vld_d  = 1'b1;
            pend_sp_d   = mw_sp;
            pend_addr_d = mw_addr;
            pend_data_d = mw_data;
        end else begin
            pend_vld_d  = 1'b0;
        end
    end

    // State registers with synchronous reset that also discards any deferred write
    always_ff @(posedge clk) begin
        if (rst) begin
            csr_q       <= '{default: 8'h00};
            npr_q       <= '{default: 8'h00};
            dirty_q     <= '0;
            pend_vld_q  <= 1'b0;
            pend_sp_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            csr_q       <= csr_d;
            npr_q       <= npr_d;
            dirty_q     <= dirty_d;
            pend_vld_q  <= pend_vld_d;
            pend_sp_q   <= pend_sp_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            err_q       <= err_d;
        end
    end

    // Microcode read port straight from registers, zero when the index is out of range
    always_comb begin
        mpRDATA = 8'h00;
        if (!mpRSPACE) begin
            for (int b = 0; b < CSR_BYTES; b++)
                if (32'(mpRADDR) == 32'(b)) mpRDATA = csr_q[b];
        end else begin
            for (int b = 0; b < NPR_BYTES; b++)
                if (32'(mpRADDR) == 32'(b)) mpRDATA = npr_q[b];
        end
    end

    assign mpBUSY   = pend_vld_q;
    assign mpERR    = err_q;
    assign csrDIRTY = dirty_q;

    for (genvar k = 0; k < NCSR; k++) begin : g_csr
        assign csrOUT[16*k +: 16] = {csr_q[2*k+1], csr_q[2*k]};
    end

    for (genvar c = 0; c < NNPR; c++) begin : g_npr
        assign nprID[16*c +: 16] = {npr_q[8*c+1], npr_q[8*c+0]};
        assign nprOD[16*c +: 16] = {npr_q[8*c+3], npr_q[8*c+2]};
        assign nprIA[16*c +: 16] = {npr_q[8*c+5], npr_q[8*c+4]};
        assign nprOA[16*c +: 16] = {npr_q[8*c+7], npr_q[8*c+6]};
    end

endmodule

// File: tb/tb_kmc_mpram_gen.sv
// Bench for kmc_mpram_gen (NCSR=4, NNPR=2): directed scenarios then random traffic.
// Latency: outputs compared 1 time unit after each rising edge against a byte-array model.
// Backpressure: the model keeps the deferred microcode write in a queue of at most one entry.
module tb_kmc_mpram_gen;

    localparam int NCSR = 4;
    localparam int NNPR = 2;
    localparam int IW   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        hostWR, hostLOBYTE, hostHIBYTE;
    logic [1:0]  hostSEL;
    logic [15:0] hostDATA;
    logic        dmaACK, dmaOUT, dmaLOBYTE, dmaHIBYTE;
    logic [0:0]  dmaCHAN;
    logic [15:0] dmaDATA;
    logic        mpWR, mpWSPACE, mpRD, mpRSPACE;
    logic [7:0]  mpWADDR, mpWDATA, mpRADDR;
    logic [7:0]  mpRDATA;
    logic        mpBUSY, mpERR;
    logic [63:0] csrOUT;
    logic [7:0]  csrDIRTY;
    logic [31:0] nprID, nprOD, nprIA, nprOA;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    kmc_mpram_gen #(.NCSR(NCSR), .NNPR(NNPR), .IW(IW)) dut (
        .clk(clk), .rst(rst),
        .hostWR(hostWR), .hostSEL(hostSEL), .hostLOBYTE(hostLOBYTE), .hostHIBYTE(hostHIBYTE),
        .hostDATA(hostDATA),
        .dmaACK(dmaACK), .dmaCHAN(dmaCHAN), .dmaOUT(dmaOUT), .dmaLOBYTE(dmaLOBYTE),
        .dmaHIBYTE(dmaHIBYTE), .dmaDATA(dmaDATA),
        .mpWR(mpWR), .mpWSPACE(mpWSPACE), .mpWADDR(mpWADDR), .mpWDATA(mpWDATA),
        .mpRD(mpRD), .mpRSPACE(mpRSPACE), .mpRADDR(mpRADDR), .mpRDATA(mpRDATA),
        .mpBUSY(mpBUSY), .mpERR(mpERR), .csrOUT(csrOUT), .csrDIRTY(csrDIRTY),
        .nprID(nprID), .nprOD(nprOD), .nprIA(nprIA), .nprOA(nprOA)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain byte arrays plus a queue holding the deferred write
    typedef struct packed {
        logic       sp;
        logic [7:0] ad;
        logic [7:0] da;
    } mw_t;

    logic [7:0] m_csr   [8];
    logic [7:0] m_npr   [16];
    logic       m_dirty [8];
    mw_t        m_pq    [$];
    logic       m_err;

    function automatic logic [7:0] m_read(input logic sp, input logic [7:0] a);
        if (!sp) return (a < 8)  ? m_csr[int'(a)] : 8'h00;
        else     return (a < 16) ? m_npr[int'(a)] : 8'h00;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin m_csr[i] = 8'h00; m_dirty[i] = 1'b0; end
        for (int i = 0; i < 16; i++) m_npr[i] = 8'h00;
        m_pq.delete();
        m_err = 1'b0;
    endtask

    task automatic m_step();
        bit   hw [8];
        bit   dw [16];
        mw_t  c;
        bit   has;
        int   base;
        if (rst) begin
            m_reset();
            return;
        end
        for (int i = 0; i < 8; i++)  hw[i] = 1'b0;
        for (int i = 0; i < 16; i++) dw[i] = 1'b0;
        if (hostWR) begin
            hw[hostSEL*2]     = hostLOBYTE;
            hw[hostSEL*2 + 1] = hostHIBYTE;
        end
        if (dmaACK) begin
            base = int'(dmaCHAN) * 8 + (dmaOUT ? 2 : 0);
            dw[base]     = dmaLOBYTE;
            dw[base + 1] = dmaHIBYTE;
        end
        m_err = mpWR && (m_pq.size() != 0);
        has = 1'b0;
        if (m_pq.size() != 0) begin
            c = m_pq[0]; has = 1'b1;
        end else if (mpWR) begin
            c = '{sp: mpWSPACE, ad: mpWADDR, da: mpWDATA}; has = 1'b1;
        end
        m_pq.delete();
        if (has && (c.ad < (c.sp ? 16 : 8))) begin
            if (c.sp ? dw[int'(c.ad)] : hw[int'(c.ad)]) m_pq.push_back(c);
            else if (c.sp) m_npr[int'(c.ad)] = c.da;
            else           m_csr[int'(c.ad)] = c.da;
        end
        for (int i = 0; i < 8; i++)
            if (hw[i]) m_csr[i] = (i % 2 == 1) ? hostDATA[15:8] : hostDATA[7:0];
        for (int i = 0; i < 16; i++)
            if (dw[i]) m_npr[i] = (i % 2 == 1) ? dmaDATA[15:8] : dmaDATA[7:0];
        if (mpRD && !mpRSPACE && mpRADDR < 8) m_dirty[int'(mpRADDR)] = 1'b0;
        for (int i = 0; i < 8; i++) if (hw[i]) m_dirty[i] = 1'b1;
    endtask

    task automatic compare_all();
        logic [63:0] ec;
        logic [7:0]  ed;
        logic [31:0] eid, eod, eia, eoa;
        for (int k = 0; k < 4; k++) ec[16*k +: 16] = {m_csr[2*k+1], m_csr[2*k]};
        for (int i = 0; i < 8; i++) ed[i] = m_dirty[i];
        for (int c = 0; c < 2; c++) begin
            eid[16*c +: 16] = {m_npr[8*c+1], m_npr[8*c+0]};
            eod[16*c +: 16] = {m_npr[8*c+3], m_npr[8*c+2]};
            eia[16*c +: 16] = {m_npr[8*c+5], m_npr[8*c+4]};
            eoa[16*c +: 16] = {m_npr[8*c+7], m_npr[8*c+6]};
        end
        chk("csrOUT",   csrOUT,   ec);
        chk("csrDIRTY", csrDIRTY, ed);
        chk("nprID",    nprID,    eid);
        chk("nprOD",    nprOD,    eod);
        chk("nprIA",    nprIA,    eia);
        chk("nprOA",    nprOA,    eoa);
        chk("mpBUSY",   mpBUSY,   m_pq.size() != 0);
        chk("mpERR",    mpERR,    m_err);
    endtask

    // One clock: check the read port, advance the model, clock the DUT, compare
    task automatic cyc();
        #1;
        chk("mpRDATA", mpRDATA, m_read(mpRSPACE, mpRADDR));
        m_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        rst = 1'b0;
        hostWR = 0; hostSEL = 0; hostLOBYTE = 0; hostHIBYTE = 0; hostDATA = 0;
        dmaACK = 0; dmaCHAN = 0; dmaOUT = 0; dmaLOBYTE = 0; dmaHIBYTE = 0; dmaDATA = 0;
        mpWR = 0; mpWSPACE = 0; mpWADDR = 0; mpWDATA = 0;
        mpRD = 0; mpRSPACE = 0; mpRADDR = 0;
    endtask

    initial begin
        idle();
        m_reset();
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_csr",   csrOUT,   64'h0);
        chk("rst_busy",  mpBUSY,   1'b0);
        chk("rst_dirty", csrDIRTY, 8'h00);

        // Host full-word write to CSR2
        idle();
        hostWR = 1; hostSEL = 2; hostLOBYTE = 1; hostHIBYTE = 1; hostDATA = 16'hBEEF;
        cyc();
        chk("t1_csr2",  csrOUT[47:32], 16'hBEEF);
        chk("t1_dirty", csrDIRTY,      8'b0011_0000);

        // Host and microcode collide on CSR byte 0
        idle();
        hostWR = 1; hostSEL = 0; hostLOBYTE = 1; hostDATA = 16'h0012;
        mpWR = 1; mpWSPACE = 0; mpWADDR = 0; mpWDATA = 8'h34;
        cyc();
        chk("t2_lose", csrOUT[7:0], 8'h12);
        chk("t2_busy", mpBUSY, 1'b1);
        idle();
        cyc();
        chk("t2_land", csrOUT[7:0], 8'h34);
        chk("t2_free", mpBUSY, 1'b0);

        // mpWR while busy is dropped and flagged
        idle();
        hostWR = 1; hostSEL = 1; hostLOBYTE = 1; hostDATA = 16'h0055;
        mpWR = 1; mpWADDR = 2; mpWDATA = 8'h66;
        cyc();
        chk("t3_busy", mpBUSY, 1'b1);
        idle();
        mpWR = 1; mpWADDR = 5; mpWDATA = 8'h77;
        cyc();
        chk("t3_err",     mpERR, 1'b1);
        chk("t3_pending", csrOUT[23:16], 8'h66);
        chk("t3_dropped", csrOUT[47:40], 8'hBE);
        idle();
        cyc();
        chk("t3_errpulse", mpERR, 1'b0);

        // DMA capture into channel 1 ID
        idle();
        dmaACK = 1; dmaCHAN = 1; dmaOUT = 0; dmaLOBYTE = 1; dmaHIBYTE = 1; dmaDATA = 16'hA55A;
        cyc();
        chk("t4_ch1", nprID[31:16], 16'hA55A);
        chk("t4_ch0", nprID[15:0],  16'h0000);

        // Dirty set beats same-cycle clear
        idle();
        mpRD = 1; mpRSPACE = 0; mpRADDR = 4;
        hostWR = 1; hostSEL = 2; hostLOBYTE = 1; hostDATA = 16'h00C3;
        cyc();
        chk("t5_keep", csrDIRTY[4], 1'b1);
        idle();
        mpRD = 1; mpRADDR = 4;
        cyc();
        chk("t5_clear", csrDIRTY[4], 1'b0);

        // Reset during deferral discards the pending write
        idle();
        hostWR = 1; hostSEL = 3; hostHIBYTE = 1; hostDATA = 16'h9900;
        mpWR = 1; mpWADDR = 7; mpWDATA = 8'hAB;
        cyc();
        chk("t6_busy", mpBUSY, 1'b1);
        idle();
        rst = 1'b1;
        cyc();
        chk("t6_rbusy", mpBUSY, 1'b0);
        chk("t6_rcsr",  csrOUT, 64'h0);
        chk("t6_rid",   nprID,  32'h0);
        idle();
        cyc();
        cyc();
        chk("t6_gone", csrOUT, 64'h0);

        // Random traffic with deliberately narrow address ranges to force collisions
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst        = ($urandom_range(0, 199) == 0);
            hostWR     = ($urandom_range(0, 2) == 0);
            hostSEL    = 2'($urandom_range(0, 3));
            hostLOBYTE = 1'($urandom);
            hostHIBYTE = 1'($urandom);
            hostDATA   = 16'($urandom);
            dmaACK     = ($urandom_range(0, 2) == 0);
            dmaCHAN    = 1'($urandom);
            dmaOUT     = 1'($urandom);
            dmaLOBYTE  = 1'($urandom);
            dmaHIBYTE  = 1'($urandom);
            dmaDATA    = 16'($urandom);
            mpWR       = ($urandom_range(0, 1) == 0);
            mpWSPACE   = 1'($urandom);
            mpWADDR    = 8'($urandom_range(0, 18));
            mpWDATA    = 8'($urandom);
            mpRD       = 1'($urandom);
            mpRSPACE   = 1'($urandom);
            mpRADDR    = 8'($urandom_range(0, 18));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
